// File: rtl/temp_state_pkg.sv
// temp_state_pkg: state codes and the shared 3-bit state type for the
// temperature classifier and the seven-segment display driver.
//   ST_NODATA   000  no sample yet, or samples stopped arriving
//   ST_LOW      001  at or below the low threshold
//   ST_HIGH     010  none of the other bands
//   ST_PELIGRO  011  extreme temperature
//   ST_CORPORAL 100  body-temperature window
package temp_state_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_NODATA   = 3'b000;
    localparam state_t ST_LOW      = 3'b001;
    localparam state_t ST_HIGH     = 3'b010;
    localparam state_t ST_PELIGRO  = 3'b011;
    localparam state_t ST_CORPORAL = 3'b100;

endpackage

// File: rtl/temp_state_fsm_if.sv
// temp_state_fsm_if: sample stream in, committed state out.
//   temp_valid   one-cycle qualifier for temp_data
//   temp_data    unsigned temperature, degrees C
//   actual_state committed state code (display encoding)
//   state_chg    one-cycle pulse when actual_state takes a new value
// master = sensor/display side, slave = classifier.
interface temp_state_fsm_if;
    import temp_state_pkg::*;

    logic       temp_valid;
    logic [7:0] temp_data;
    state_t     actual_state;
    logic       state_chg;

    modport master (
        output temp_valid,
        output temp_data,
        input  actual_state,
        input  state_chg
    );

    modport slave (
        input  temp_valid,
        input  temp_data,
        output actual_state,
        output state_chg
    );

endinterface

// File: rtl/temp_band_classify.sv
// temp_band_classify: purely combinational map from a temperature sample
// to its band code. Priority: PELIGRO, then CORPORAL window, then LOW,
// otherwise HIGH.
//   temp_data  in  8-bit unsigned temperature
//   band       out band code (never ST_NODATA)
module temp_band_classify
    import temp_state_pkg::*;
#(
    parameter int LOW_MAX     = 20,
    parameter int BODY_MIN    = 35,
    parameter int BODY_MAX    = 40,
    parameter int EXTREME_MIN = 60
) (
    input  logic [7:0] temp_data,
    output state_t     band
);

    localparam logic [7:0] LOW_MAX_8     = 8'(LOW_MAX);
    localparam logic [7:0] BODY_MIN_8    = 8'(BODY_MIN);
    localparam logic [7:0] BODY_MAX_8    = 8'(BODY_MAX);
    localparam logic [7:0] EXTREME_MIN_8 = 8'(EXTREME_MIN);

    always_comb begin
        band = ST_HIGH;
        if (temp_data >= EXTREME_MIN_8) begin
            band = ST_PELIGRO;
        end else if (temp_data >= BODY_MIN_8 && temp_data <= BODY_MAX_8) begin
            band = ST_CORPORAL;
        end else if (temp_data <= LOW_MAX_8) begin
            band = ST_LOW;
        end
    end

endmodule

// File: rtl/temp_state_fsm.sv
// temp_state_fsm: debounced temperature band classifier with a sample
// watchdog. Band changes commit after CONFIRM consecutive samples in the
// new band; PELIGRO and the first sample after reset/timeout commit at once.
// With no sample for TIMEOUT_CYC cycles the state falls back to NODATA.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport: temp_valid/temp_data in, actual_state/state_chg out
module temp_state_fsm
    import temp_state_pkg::*;
#(
    parameter int LOW_MAX     = 20,
    parameter int BODY_MIN    = 35,
    parameter int BODY_MAX    = 40,
    parameter int EXTREME_MIN = 60,
    parameter int CONFIRM     = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    temp_state_fsm_if.slave   bus
);

    localparam int           WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]   CONFIRM_4 = 4'(CONFIRM);

    state_t          state_q, state_n;
    state_t          cand_q, cand_n;
    logic [3:0]      cnt_q, cnt_n;
    logic [WD_W-1:0] wdog_q, wdog_n;
    logic            chg_q, chg_n;
    state_t          band;
    logic            commit;
    logic [3:0]      cnt_inc;

    temp_band_classify #(
        .LOW_MAX    (LOW_MAX),
        .BODY_MIN   (BODY_MIN),
        .BODY_MAX   (BODY_MAX),
        .EXTREME_MIN(EXTREME_MIN)
    ) u_classify (
        .temp_data(bus.temp_data),
        .band     (band)
    );

    assign cnt_inc = cnt_q + 4'd1;

    // A valid sample always takes precedence over the watchdog, so the
    // timeout branch is only reached in cycles without a sample.
    always_comb begin
        state_n = state_q;
        cand_n  = cand_q;
        cnt_n   = cnt_q;
        wdog_n  = wdog_q;
        chg_n   = 1'b0;
        commit  = 1'b0;

        if (bus.temp_valid) begin
            wdog_n = '0;
            if (state_q == ST_NODATA ||
                (band == ST_PELIGRO && state_q != ST_PELIGRO)) begin
                commit = 1'b1;
            end else if (band == state_q) begin
                cand_n = ST_NODATA;
                cnt_n  = '0;
            end else if (band == cand_q) begin
                cnt_n = cnt_inc;
                if (cnt_inc == CONFIRM_4) begin
                    commit = 1'b1;
                end
            end else begin
                cand_n = band;
                cnt_n  = 4'd1;
                if (CONFIRM_4 == 4'd1) begin
                    commit = 1'b1;
                end
            end

            if (commit) begin
                state_n = band;
                cand_n  = ST_NODATA;
                cnt_n   = '0;
                chg_n   = 1'b1;
            end
        end else if (wdog_q == WD_MAX) begin
            // Saturated: fall back once; stays silent while already NODATA.
            if (state_q != ST_NODATA) begin
                state_n = ST_NODATA;
                cand_n  = ST_NODATA;
                cnt_n   = '0;
                chg_n   = 1'b1;
            end
        end else begin
            wdog_n = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NODATA;
            cand_q  <= ST_NODATA;
            cnt_q   <= '0;
            wdog_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cand_q  <= cand_n;
            cnt_q   <= cnt_n;
            wdog_q  <= wdog_n;
            chg_q   <= chg_n;
        end
    end

    assign bus.actual_state = state_q;
    assign bus.state_chg    = chg_q;

endmodule

// File: tb/tb_temp_state_fsm.sv
// tb_temp_state_fsm: directed test of temp_state_fsm with TIMEOUT_CYC=16.
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that consumed the sample.
module tb_temp_state_fsm;
    import temp_state_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    temp_state_fsm_if bus ();

    temp_state_fsm #(
        .LOW_MAX    (20),
        .BODY_MIN   (35),
        .BODY_MAX   (40),
        .EXTREME_MIN(60),
        .CONFIRM    (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0] cls_in;
    state_t     cls_out;

    temp_band_classify #(
        .LOW_MAX    (20),
        .BODY_MIN   (35),
        .BODY_MAX   (40),
        .EXTREME_MIN(60)
    ) u_ref (
        .temp_data(cls_in),
        .band     (cls_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic send(input logic [7:0] t);
        bus.temp_valid = 1'b1;
        bus.temp_data  = t;
        @(negedge clk);
        bus.temp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b1;
        bus.temp_valid = 1'b0;
        bus.temp_data  = 8'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.actual_state !== ST_NODATA || bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: state=%b chg=%b expected 000/0", bus.actual_state, bus.state_chg);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_classify();
        logic [7:0] vin [12]  = '{8'd0, 8'd20, 8'd21, 8'd34, 8'd35, 8'd37,
                                  8'd40, 8'd41, 8'd59, 8'd60, 8'd200, 8'd255};
        state_t     vexp [12] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100,
                                  3'b100, 3'b010, 3'b010, 3'b011, 3'b011, 3'b011};
        for (int i = 0; i < 12; i++) begin
            cls_in = vin[i];
            #1;
            tests_run++;
            if (cls_out !== vexp[i]) begin
                tests_failed++;
                $display("FAIL classify_%0d: band=%b expected %b", vin[i], cls_out, vexp[i]);
            end
        end
    endtask

    task automatic test_first_sample();
        send(8'd37);
        tests_run++;
        if (bus.actual_state !== 3'b100 || bus.state_chg !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_commit: state=%b chg=%b expected 100/1", bus.actual_state, bus.state_chg);
        end
        @(negedge clk);
        tests_run++;
        if (bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_pulse_width: chg=%b expected 0", bus.state_chg);
        end
        for (int i = 0; i < 4; i++) begin
            send(8'd37);
            tests_run++;
            if (bus.actual_state !== 3'b100 || bus.state_chg !== 1'b0) begin
                tests_failed++;
                $display("FAIL same_band_%0d: state=%b chg=%b expected 100/0", i, bus.actual_state, bus.state_chg);
            end
        end
    endtask

    task automatic test_debounce();
        for (int i = 0; i < 4; i++) begin
            send(8'd10);
            tests_run++;
            if (i < 3 && (bus.actual_state !== 3'b100 || bus.state_chg !== 1'b0)) begin
                tests_failed++;
                $display("FAIL to_low_wait_%0d: state=%b chg=%b expected 100/0", i, bus.actual_state, bus.state_chg);
            end else if (i == 3 && (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b1)) begin
                tests_failed++;
                $display("FAIL to_low_commit: state=%b chg=%b expected 001/1", bus.actual_state, bus.state_chg);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send(i < 3 ? 8'd25 : 8'd10);
            tests_run++;
            if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0) begin
                tests_failed++;
                $display("FAIL interrupted_%0d: state=%b chg=%b expected 001/0", i, bus.actual_state, bus.state_chg);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send(8'd25);
            tests_run++;
            if (i < 3 && (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0)) begin
                tests_failed++;
                $display("FAIL to_high_wait_%0d: state=%b chg=%b expected 001/0", i, bus.actual_state, bus.state_chg);
            end else if (i == 3 && (bus.actual_state !== 3'b010 || bus.state_chg !== 1'b1)) begin
                tests_failed++;
                $display("FAIL to_high_commit: state=%b chg=%b expected 010/1", bus.actual_state, bus.state_chg);
            end
        end
    endtask

    task automatic test_peligro_bypass();
        send(8'd60);
        tests_run++;
        if (bus.actual_state !== 3'b011 || bus.state_chg !== 1'b1) begin
            tests_failed++;
            $display("FAIL bypass: state=%b chg=%b expected 011/1", bus.actual_state, bus.state_chg);
        end
        // First 59 opens the HIGH candidate; third of the next four commits.
        for (int i = 0; i < 5; i++) begin
            send(8'd59);
            tests_run++;
            if (i < 3 && (bus.actual_state !== 3'b011 || bus.state_chg !== 1'b0)) begin
                tests_failed++;
                $display("FAIL leave_peligro_wait_%0d: state=%b chg=%b expected 011/0", i, bus.actual_state, bus.state_chg);
            end else if (i == 3 && (bus.actual_state !== 3'b010 || bus.state_chg !== 1'b1)) begin
                tests_failed++;
                $display("FAIL leave_peligro_commit: state=%b chg=%b expected 010/1", bus.actual_state, bus.state_chg);
            end else if (i == 4 && (bus.actual_state !== 3'b010 || bus.state_chg !== 1'b0)) begin
                tests_failed++;
                $display("FAIL leave_peligro_after: state=%b chg=%b expected 010/0", bus.actual_state, bus.state_chg);
            end
        end
    endtask

    task automatic test_alternating();
        repeat (4) send(8'd10);
        tests_run++;
        if (bus.actual_state !== 3'b001) begin
            tests_failed++;
            $display("FAIL alt_setup: state=%b expected 001", bus.actual_state);
        end
        for (int i = 0; i < 20; i++) begin
            send((i % 2 == 0) ? 8'd25 : 8'd37);
            tests_run++;
            if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0) begin
                tests_failed++;
                $display("FAIL alternating_%0d: state=%b chg=%b expected 001/0", i, bus.actual_state, bus.state_chg);
            end
        end
    endtask

    task automatic test_timeout();
        repeat (15) @(negedge clk);
        tests_run++;
        if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: state=%b chg=%b expected 001/0", bus.actual_state, bus.state_chg);
        end
        @(negedge clk);
        tests_run++;
        if (bus.actual_state !== 3'b000 || bus.state_chg !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_fire: state=%b chg=%b expected 000/1", bus.actual_state, bus.state_chg);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.actual_state !== 3'b000 || bus.state_chg !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_silent_%0d: state=%b chg=%b expected 000/0", i, bus.actual_state, bus.state_chg);
            end
        end
        send(8'd10);
        tests_run++;
        if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_timeout_commit: state=%b chg=%b expected 001/1", bus.actual_state, bus.state_chg);
        end
        // Sample lands in the exact cycle the watchdog would fire.
        repeat (15) @(negedge clk);
        send(8'd37);
        tests_run++;
        if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL sample_wins: state=%b chg=%b expected 001/0", bus.actual_state, bus.state_chg);
        end
        repeat (15) @(negedge clk);
        tests_run++;
        if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL wdog_cleared: state=%b chg=%b expected 001/0", bus.actual_state, bus.state_chg);
        end
        @(negedge clk);
        tests_run++;
        if (bus.actual_state !== 3'b000 || bus.state_chg !== 1'b1) begin
            tests_failed++;
            $display("FAIL second_timeout: state=%b chg=%b expected 000/1", bus.actual_state, bus.state_chg);
        end
    endtask

    task automatic test_reset_mid();
        send(8'd10);
        repeat (3) send(8'd25);
        tests_run++;
        if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_setup: state=%b chg=%b expected 001/0", bus.actual_state, bus.state_chg);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.actual_state !== 3'b000 || bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: state=%b chg=%b expected 000/0", bus.actual_state, bus.state_chg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'd10);
        tests_run++;
        if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_commit: state=%b chg=%b expected 001/1", bus.actual_state, bus.state_chg);
        end
        send(8'd25);
        tests_run++;
        if (bus.actual_state !== 3'b001 || bus.state_chg !== 1'b0) begin
            tests_failed++;
            $display("FAIL cand_discarded: state=%b chg=%b expected 001/0", bus.actual_state, bus.state_chg);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cls_in       = 8'd0;
        test_reset();
        test_classify();
        test_first_sample();
        test_debounce();
        test_peligro_bypass();
        test_alternating();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/temp_state_fsm.md
# temp_state_fsm

Temperature classifier that produces the 3-bit `actual_state` code consumed by the seven-segment display driver. It takes 8-bit unsigned temperature samples (°C) with a valid strobe and maps each sample to a band: no-data, Low, High, Peligro (extreme) or Corporal (body). It debounces band changes over consecutive samples and falls back to no-data when samples stop arriving. It sits between the sensor/ADC front end and the display.

## Interface
- `LOW_MAX`, 20: highest temperature classified as Low.
- `BODY_MIN`, 35: lowest temperature classified as Corporal.
- `BODY_MAX`, 40: highest temperature classified as Corporal.
- `EXTREME_MIN`, 60: lowest temperature classified as Peligro.
- `CONFIRM`, 4: consecutive samples in a new band required to commit it (legal range 1..15).
- `TIMEOUT_CYC`, 1_000_000: clock cycles without a sample before the block falls back to no-data (must be ≥2).
- `clk` input 1: the single clock; everything is clocked on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `temp_valid` input 1: one-cycle qualifier for `temp_data`.
- `temp_data` input 8: unsigned temperature in °C.
- `actual_state` output 3: committed state code (display encoding).
- `state_chg` output 1: one-cycle pulse in the same cycle `actual_state` takes a new value.

## Operation
- State codes: 000 NODATA, 001 LOW, 010 HIGH, 011 PELIGRO, 100 CORPORAL. Codes 101–111 are never driven.
- Band of a sample, in priority order:
  - t ≥ EXTREME_MIN → PELIGRO.
  - else BODY_MIN ≤ t ≤ BODY_MAX → CORPORAL.
  - else t ≤ LOW_MAX → LOW.
  - else → HIGH.
- Internal registers: `cand` (3 bits), `cnt` (4 bits), `wdog` (sized with $clog2(TIMEOUT_CYC)).
- Each cycle with `temp_valid`=1, sample band is `b`. Rules, highest priority first:
  - `actual_state`==NODATA → commit `b` immediately. This is the first sample after reset or timeout.
  - `b`==PELIGRO and `actual_state`≠PELIGRO → commit immediately. This is the safety bypass; no debounce.
  - `b`==`actual_state` → clear `cand` to NODATA and `cnt` to 0. No change.
  - `b`==`cand` → increment `cnt`. When the incremented value equals CONFIRM, commit `b`.
  - otherwise → `cand`←`b`, `cnt`←1. If CONFIRM==1, commit `b` immediately.
- Commit: `actual_state`←`b`, `cand`←NODATA, `cnt`←0, `state_chg`←1 for one cycle.
- Watchdog:
  - `wdog` clears on every valid sample.
  - Otherwise `wdog` increments, saturating at TIMEOUT_CYC-1.
  - When it reaches TIMEOUT_CYC-1 with `actual_state`≠NODATA: `actual_state`←NODATA, `cand`/`cnt` cleared, `state_chg` pulses.
  - While already in NODATA, the timeout is silent.
- Simultaneous events: a valid sample in the same cycle as the timeout wins. The sample is processed and `wdog` is cleared.
- Reset (asynchronous, any time): `actual_state`=000, `state_chg`=0, `cand`=000, `cnt`=0, `wdog`=0. A partially confirmed candidate is discarded.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Commit latency: `actual_state` and `state_chg` update on the clock edge that samples the deciding `temp_valid`. They are visible the next cycle.
- `state_chg` is high exactly one cycle per change. There is never a pulse without a value change.
- Timeout fires TIMEOUT_CYC cycles after the last valid sample.
- No backpressure: every sample presented with `temp_valid` is consumed. Back-to-back valid cycles are legal.

## Structure
- Package `temp_state_pkg`:
  - State code localparams `ST_NODATA`, `ST_LOW`, `ST_HIGH`, `ST_PELIGRO`, `ST_CORPORAL`.
  - The shared 3-bit state type.
  - The display driver uses the same constants.
- Sub-module `temp_band_classify`: purely combinational. Maps `temp_data` to a band code using the four threshold parameters. It is reused by the test bench as a reference model.
- The top holds the commit/debounce logic and the watchdog counter.

## Test plan
- Reset, then one sample of 37 → next cycle `actual_state`=100, `state_chg`=1 for one cycle. Then 4×37 → no further pulse.
- From LOW (sample 10), send 25,25,25 then 10 → stays 001, `cnt` cleared. Then 25×4 → changes to 010 on the 4th sample.
- From HIGH, one sample of 60 → 011 next cycle (bypass). One sample of 59 → still 011. Then 59 ×4 → 010.
- Alternating 25/37 from LOW for 20 samples → never leaves 001, no `state_chg`.
- TIMEOUT_CYC=16: from 001, withhold `temp_valid` → 000 with a pulse 16 cycles after the last sample. A sample in the exact timeout cycle keeps the state and clears the watchdog.
- Assert `rst_n` low mid-debounce (`cnt`=3) → outputs 000/0 immediately. After release, the first sample commits directly.
